// File: rtl/rgb_out_if.sv
// rtl/rgb_out_if.sv - pixel bus between the pixel generator and the DAC output stage
interface rgb_out_if #(
    parameter int CH   = 3,
    parameter int BITS = 8
);
    logic                     ena;
    logic                     blank;
    logic                     frame;
    logic [1:0]               mode;
    logic [CH-1:0]            chan_en;
    logic [CH*(BITS+2)-1:0]   din;
    logic [CH*BITS-1:0]       dout;

    modport master (
        output ena, blank, frame, mode, chan_en, din,
        input  dout
    );

    modport slave (
        input  ena, blank, frame, mode, chan_en, din,
        output dout
    );
endinterface

// File: rtl/rgb_out_stage.sv
// rtl/rgb_out_stage.sv - registered DAC colour drive with blanking, dithering, test ramp and freeze
module rgb_out_stage #(
    parameter int CH   = 3,
    parameter int BITS = 8,
    parameter int PIPE = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    rgb_out_if.slave bus
);
    localparam int W  = CH * BITS;
    localparam int DW = BITS + 2;

    typedef enum logic [1:0] {
        M_PASS   = 2'b00,
        M_DITHER = 2'b01,
        M_TEST   = 2'b10,
        M_HOLD   = 2'b11
    } mode_t;

    mode_t           mode;
    logic            x_par;
    logic [BITS-1:0] ramp;
    logic [1:0]      fcnt;
    logic [1:0]      thr;
    logic            advance;
    logic [W-1:0]    s1_d;
    logic [W-1:0]    stage_q [PIPE];

    assign mode    = mode_t'(bus.mode);
    assign advance = bus.ena && (mode != M_HOLD);

    // Ordered 2x2 threshold so the bump alternates in both pixel and frame
    always_comb begin
        thr = 2'd0;
        case ({x_par, fcnt[0]})
            2'b00:   thr = 2'd0;
            2'b01:   thr = 2'd2;
            2'b10:   thr = 2'd3;
            default: thr = 2'd1;
        endcase
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [BITS-1:0] ival;
        logic [BITS-1:0] chv;
        logic [1:0]      frac;
        logic            bump;

        assign ival = bus.din[k*DW+2 +: BITS];
        assign frac = bus.din[k*DW +: 2];
        // Suppressing the bump at full scale gives saturation without a wide adder
        assign bump = (frac > thr) && !(&ival);

        always_comb begin
            chv = '0;
            if (!bus.blank && bus.chan_en[k]) begin
                case (mode)
                    M_PASS:   chv = ival;
                    M_DITHER: chv = ival + BITS'(bump);
                    M_TEST:   chv = (k % 2 == 0) ? ramp : ~ramp;
                    default:  chv = '0;
                endcase
            end
        end

        assign s1_d[k*BITS +: BITS] = chv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_par <= 1'b0;
            ramp  <= '0;
            fcnt  <= 2'd0;
            for (int i = 0; i < PIPE; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            if (bus.frame) begin
                fcnt <= fcnt + 2'd1;
            end
            if (advance) begin
                stage_q[0] <= s1_d;
                for (int i = 1; i < PIPE; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
                if (bus.blank) begin
                    x_par <= 1'b0;
                    ramp  <= '0;
                end else begin
                    x_par <= ~x_par;
                    ramp  <= ramp + BITS'(1);
                end
            end
        end
    end

    assign bus.dout = stage_q[PIPE-1];
endmodule

// File: tb/tb_rgb_out_stage.sv
// tb/tb_rgb_out_stage.sv - self-checking bench for rgb_out_stage (PIPE=1 and PIPE=2 instances)
module tb_rgb_out_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena, blank, frame;
    logic [1:0]  mode;
    logic [2:0]  chan_en;
    logic [29:0] din;

    int passed = 0;
    int total  = 0;

    rgb_out_if #(.CH(3), .BITS(8)) if1 ();
    rgb_out_if #(.CH(3), .BITS(8)) if2 ();

    assign if1.ena = ena;     assign if2.ena = ena;
    assign if1.blank = blank; assign if2.blank = blank;
    assign if1.frame = frame; assign if2.frame = frame;
    assign if1.mode = mode;   assign if2.mode = mode;
    assign if1.chan_en = chan_en; assign if2.chan_en = chan_en;
    assign if1.din = din;     assign if2.din = din;

    rgb_out_stage #(.CH(3), .BITS(8), .PIPE(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    rgb_out_stage #(.CH(3), .BITS(8), .PIPE(2)) d2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    always #5 clk = ~clk;

    // Reference model: history of every pixel accepted into the pipe
    logic [23:0] hist[$];
    int m_xpar, m_ramp, m_fcnt;

    function automatic logic [29:0] rep(logic [9:0] v);
        return {v, v, v};
    endfunction

    function automatic logic [23:0] pixel(logic [1:0] md, logic bl, logic [2:0] ce,
                                          logic [29:0] d, int xp, int rp, int fc);
        logic [23:0] r = '0;
        int idx = xp * 2 + (fc % 2);
        int t = (idx == 0) ? 0 : (idx == 1) ? 2 : (idx == 2) ? 3 : 1;
        for (int k = 0; k < 3; k++) begin
            int raw = int'((d >> (10 * k)) & 30'h3FF);
            int v = 0;
            if (!bl && ce[k]) begin
                case (md)
                    2'd0: v = raw / 4;
                    2'd1: begin
                        v = raw / 4 + (((raw % 4) > t) ? 1 : 0);
                        if (v > 255) v = 255;
                    end
                    default: v = (k % 2 == 0) ? rp : 255 - rp;
                endcase
            end
            r[8*k +: 8] = v[7:0];
        end
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (3) hist.push_back(24'h0);
        m_xpar = 0; m_ramp = 0; m_fcnt = 0;
    endtask

    task automatic model_step();
        if (ena && mode != 2'b11) begin
            hist.push_back(pixel(mode, blank, chan_en, din, m_xpar, m_ramp, m_fcnt));
            if (hist.size() > 8) void'(hist.pop_front());
            if (blank) begin
                m_xpar = 0; m_ramp = 0;
            end else begin
                m_xpar = 1 - m_xpar; m_ramp = (m_ramp + 1) % 256;
            end
        end
        if (frame) m_fcnt = (m_fcnt + 1) % 4;
    endtask

    function automatic logic [23:0] model_out(int p);
        return hist[hist.size() - p];
    endfunction

    task automatic check(string name, logic [23:0] act, logic [23:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic set_in(logic e, logic b, logic f, logic [1:0] m, logic [2:0] c, logic [29:0] d);
        ena = e; blank = b; frame = f; mode = m; chan_en = c; din = d;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0, 2'd0, 3'b111, 30'h0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        e, b, f;
        logic [1:0]  m;
        logic [2:0]  c;
        logic [29:0] d;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 3'b111, rep(10'h2A7), 24'hA9A9A9};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd1, 3'b111, rep(10'h102), 24'h404040};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd1, 3'b111, rep(10'h102), 24'h414141};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 2'd1, 3'b111, rep(10'h102), 24'h404040};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'd1, 3'b111, rep(10'h102), 24'h404040};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 2'd1, 3'b111, rep(10'h102), 24'h414141};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'd1, 3'b111, rep(10'h3FF), 24'hFFFFFF};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 2'd0, 3'b111, rep(10'h3FF), 24'h000000};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 3'b101, rep(10'h3FF), 24'hFF00FF};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'd2, 3'b111, 30'h0ABCDEF0,  24'h01FE01};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 2'd2, 3'b111, 30'h0ABCDEF0,  24'h01FE01};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 2'd2, 3'b111, rep(10'h3FF), 24'h02FD02};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 2'd3, 3'b111, rep(10'h155), 24'h02FD02};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 2'd2, 3'b111, rep(10'h000), 24'h03FC03};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 2'd0, 3'b111, rep(10'h102), 24'h03FC03};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 2'd1, 3'b111, rep(10'h102), 24'h414141};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 2'd1, 3'b111, rep(10'h102), 24'h404040};

        do_reset();
        check("reset d1", if1.dout, 24'h0);
        check("reset d2", if2.dout, 24'h0);

        // Directed table on the PIPE=1 instance
        for (int i = 0; i < 17; i++) begin
            set_in(tbl[i].e, tbl[i].b, tbl[i].f, tbl[i].m, tbl[i].c, tbl[i].d);
            step();
            check($sformatf("tbl[%0d]", i), if1.dout, tbl[i].exp);
        end

        // Latency on PIPE=2, then asynchronous reset without a clock edge
        do_reset();
        set_in(1'b1, 1'b0, 1'b0, 2'd0, 3'b111, rep(10'h2A7));
        step();
        check("lat2 first edge", if2.dout, 24'h0);
        check("lat1 first edge", if1.dout, 24'hA9A9A9);
        step();
        check("lat2 second edge", if2.dout, 24'hA9A9A9);
        din = rep(10'h123);
        step();
        #1 rst_n = 1'b0;
        #1;
        check("async rst d1", if1.dout, 24'h0);
        check("async rst d2", if2.dout, 24'h0);
        #1 rst_n = 1'b1;
        model_reset();

        // Hold freezes the PIPE=2 pipe; resume delivers the in-flight pixel
        set_in(1'b1, 1'b0, 1'b0, 2'd0, 3'b111, rep(10'h004)); step();
        din = rep(10'h008); step();
        check("hold pre A", if2.dout, 24'h010101);
        din = rep(10'h00C); step();
        check("hold pre B", if2.dout, 24'h020202);
        mode = 2'd3;
        for (int i = 0; i < 5; i++) begin
            din = 30'($urandom); blank = i[0];
            step();
            check($sformatf("hold frozen %0d", i), if2.dout, 24'h020202);
        end
        set_in(1'b1, 1'b0, 1'b0, 2'd0, 3'b111, rep(10'h010)); step();
        check("resume C", if2.dout, 24'h030303);
        din = rep(10'h014); step();
        check("resume D", if2.dout, 24'h040404);

        // Ramp: blank pulse then 258 unblanked pixels with occasional ena gaps
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 2'd2, 3'b111, 30'h0); step();
        blank = 1'b0;
        for (int i = 0; i < 258; i++) begin
            logic [7:0] r;
            r = 8'(i);
            ena = 1'b1; din = 30'($urandom);
            step();
            check($sformatf("ramp %0d", i), if1.dout, {r, ~r, r});
            if (i % 64 == 10) begin
                ena = 1'b0; step();
                check($sformatf("ramp gap %0d", i), if1.dout, {r, ~r, r});
            end
        end

        // Randomized run against the reference model on both instances
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                check("rand async rst d1", if1.dout, 24'h0);
                check("rand async rst d2", if2.dout, 24'h0);
                model_reset();
                rst_n = 1'b1;
            end
            ena     = ($urandom_range(0, 3) != 0);
            blank   = ($urandom_range(0, 7) == 0);
            frame   = ($urandom_range(0, 9) == 0);
            mode    = 2'($urandom_range(0, 3));
            chan_en = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            din     = 30'($urandom);
            step();
            check($sformatf("rand d1 %0d", n), if1.dout, model_out(1));
            check($sformatf("rand d2 %0d", n), if2.dout, model_out(2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
